id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline register for the RV32 pipelined core.
- Sits between decode and execute, and adds the following on top of a plain register stage:
  - a valid bit;
  - source-register index tracking;
  - a built-in load-use hazard detector that stalls fetch/decode and inserts a bubble;
  - a branch/jump flush;
  - an external freeze;
  - a saturating bubble counter for performance monitoring.

Parameters:
- NBits, 32, datapath width (PC, operands, immediate).
- REG_AW, 5, register index width.
- CTRL_W, 12, width of the packed control bundle (reg_write, mem_to_reg[1:0], jalr, branch, mem_read, mem_write, alu_op[2:0], alu_src, auipc).
- MEM_READ_BIT, 5, bit position of mem_read inside the control bundle.
- REG_WRITE_BIT, 0, bit position of reg_write inside the control bundle.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  decode slot holds a real instruction.
- pc_i  in  NBits  PC of the decoded instruction.
- pc_4_i  in  NBits  PC+4.
- rs1_data_i  in  NBits  register file read data 1.
- rs2_data_i  in  NBits  register file read data 2.
- imm_i  in  NBits  sign-extended immediate.
- rs1_addr_i  in  REG_AW  inst[19:15].
- rs2_addr_i  in  REG_AW  inst[24:20].
- rd_addr_i  in  REG_AW  inst[11:7].
- funct3_i  in  3  inst[14:12].
- funct7_i  in  1  inst[30].
- ctrl_i  in  CTRL_W  packed control from the control unit.
- flush_i  in  1  branch/jump taken in EX; kill the instruction being loaded.
- freeze_i  in  1  external stall (memory wait); hold the stage.
- ex_valid_o  out  1  EX slot holds a real instruction.
- ex_pc_o  out  NBits  registered pc_i.
- ex_pc_4_o  out  NBits  registered pc_4_i.
- ex_rs1_data_o  out  NBits  registered rs1_data_i.
- ex_rs2_data_o  out  NBits  registered rs2_data_i.
- ex_imm_o  out  NBits  registered imm_i.
- ex_rs1_addr_o  out  REG_AW  registered rs1_addr_i (for forwarding).
- ex_rs2_addr_o  out  REG_AW  registered rs2_addr_i (for forwarding).
- ex_rd_addr_o  out  REG_AW  registered rd_addr_i.
- ex_funct3_o  out  3  registered funct3_i.
- ex_funct7_o  out  1  registered funct7_i.
- ex_ctrl_o  out  CTRL_W  registered ctrl_i, gated by valid.
- hazard_stall_o  out  1  combinational; hold PC and IF/ID this cycle.
- bubble_count_o  out  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset:
  - While reset=1, all registered outputs and bubble_count_o are 0, asynchronously.
  - hazard_stall_o=0 follows from ex_valid_o=0.
  - Reset asserted mid-operation discards the in-flight instruction.
- Hazard detect (combinational):
  - hazard = ex_valid_o & ex_ctrl_o[MEM_READ_BIT] & (ex_rd_addr_o!=0) & id_valid_i & (ex_rd_addr_o==rs1_addr_i | ex_rd_addr_o==rs2_addr_i).
  - hazard_stall_o = hazard & ~flush_i.
  - rs2 is compared unconditionally (conservative).
- Per-rising-edge update, priority highest first:
  1. flush_i=1: ex_valid_o←0, ex_ctrl_o←0, all data/index fields←0. Flush overrides freeze_i and hazard.
  2. freeze_i=1: every register holds. Counter holds.
  3. hazard=1: bubble inserted. ex_valid_o←0, ex_ctrl_o←0, all data/index fields←0; bubble_count_o increments unless already all-ones.
  4. Otherwise, load:
     - ex_valid_o←id_valid_i;
     - ex_ctrl_o←ctrl_i if id_valid_i=1, else 0;
     - all data/index/funct fields←inputs.
- Latency: 1 cycle from input to output on a load.
- A bubble lasts exactly one cycle. The next cycle, ex_valid_o=0 so hazard clears, and the held decode instruction loads.
- Invariants:
  - ex_valid_o=0 implies ex_ctrl_o==0, so a killed or bubbled slot can never write registers or memory.
  - rd=x0 never triggers a hazard.
- Counter: saturates at 2^CNT_W-1, with no wrap. It is cleared only by reset.

Test Plan:
- Reset and load:
  - Stimulus: reset=1, then release; drive id_valid=1, pc=0x40, rs1_data=0x1234, rd=7, ctrl=0x0A1.
  - Required: outputs stay 0 until the first edge, then match the inputs; ex_valid=1.
- Load-use hazard:
  - Stimulus: EX holds lw x5 (mem_read=1, rd=5, valid); ID drives add with rs1=5.
  - Required: hazard_stall_o=1; after the edge, ex_valid=0, ex_ctrl=0, bubble_count=1. On the next edge the add loads with ex_rs1_addr=5.
- No hazard cases:
  - Stimulus: EX lw with rd=0 against ID rs1=0; separately, EX with mem_read=0, rd=5 against ID rs1=5.
  - Required: hazard_stall_o=0 and a normal load in both cases.
- Flush:
  - Stimulus: flush_i=1 together with a hazard and freeze_i=1.
  - Required: after the edge, all outputs are 0; bubble_count unchanged; hazard_stall_o=0 during the flush cycle.
- Freeze:
  - Stimulus: freeze_i=1 for 3 cycles while the inputs change.
  - Required: outputs hold their previous values; counter constant.
- Saturation:
  - Stimulus: CNT_W=2; force 5 consecutive hazard/load pairs.
  - Required: bubble_count reaches 3 and stays at 3.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_reg_if
// Bundles every signal between the decode side and the ID/EX stage register.
//   master : decode/control side. Drives the id_* fields and flush/freeze.
//            Observes the registered ex_* fields, hazard_stall_o and
//            bubble_count_o.
//   slave  : the stage register itself (id_ex_stage_reg).
// Parameters mirror the stage register: NBits datapath, REG_AW register index,
// CTRL_W packed control bundle, CNT_W bubble counter.
// ----------------------------------------------------------------------------
interface id_ex_stage_reg_if #(
    parameter int NBits  = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
);
    logic              id_valid_i;
    logic [NBits-1:0]  pc_i;
    logic [NBits-1:0]  pc_4_i;
    logic [NBits-1:0]  rs1_data_i;
    logic [NBits-1:0]  rs2_data_i;
    logic [NBits-1:0]  imm_i;
    logic [REG_AW-1:0] rs1_addr_i;
    logic [REG_AW-1:0] rs2_addr_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic [2:0]        funct3_i;
    logic              funct7_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              flush_i;
    logic              freeze_i;

    logic              ex_valid_o;
    logic [NBits-1:0]  ex_pc_o;
    logic [NBits-1:0]  ex_pc_4_o;
    logic [NBits-1:0]  ex_rs1_data_o;
    logic [NBits-1:0]  ex_rs2_data_o;
    logic [NBits-1:0]  ex_imm_o;
    logic [REG_AW-1:0] ex_rs1_addr_o;
    logic [REG_AW-1:0] ex_rs2_addr_o;
    logic [REG_AW-1:0] ex_rd_addr_o;
    logic [2:0]        ex_funct3_o;
    logic              ex_funct7_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic              hazard_stall_o;
    logic [CNT_W-1:0]  bubble_count_o;

    modport master (
        output id_valid_i, pc_i, pc_4_i, rs1_data_i, rs2_data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7_i, ctrl_i,
               flush_i, freeze_i,
        input  ex_valid_o, ex_pc_o, ex_pc_4_o, ex_rs1_data_o, ex_rs2_data_o,
               ex_imm_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
               ex_funct3_o, ex_funct7_o, ex_ctrl_o, hazard_stall_o,
               bubble_count_o
    );

    modport slave (
        input  id_valid_i, pc_i, pc_4_i, rs1_data_i, rs2_data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7_i, ctrl_i,
               flush_i, freeze_i,
        output ex_valid_o, ex_pc_o, ex_pc_4_o, ex_rs1_data_o, ex_rs2_data_o,
               ex_imm_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
               ex_funct3_o, ex_funct7_o, ex_ctrl_o, hazard_stall_o,
               bubble_count_o
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register for the RV32 pipelined core, with a valid bit,
// source-index tracking for forwarding, a load-use hazard detector that
// stalls fetch/decode and inserts a bubble, a branch/jump flush, an
// external freeze, and a saturating count of inserted bubbles.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every register and the counter
//   bus   : id_ex_stage_reg_if.slave -- decode inputs, flush/freeze,
//           registered EX outputs, hazard_stall_o, bubble_count_o
// Update priority on each edge: flush > freeze > hazard bubble > load.
// ----------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int NBits         = 32,
    parameter int REG_AW        = 5,
    parameter int CTRL_W        = 12,
    parameter int MEM_READ_BIT  = 5,
    parameter int REG_WRITE_BIT = 0,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    id_ex_stage_reg_if.slave bus
);
    // Catch a control-bundle layout that does not fit the chosen width.
    if (MEM_READ_BIT >= CTRL_W || REG_WRITE_BIT >= CTRL_W ||
        MEM_READ_BIT == REG_WRITE_BIT) begin : g_bad_ctrl_layout
        $error("id_ex_stage_reg: control bit positions do not fit CTRL_W");
    end

    typedef struct packed {
        logic              valid;
        logic [NBits-1:0]  pc;
        logic [NBits-1:0]  pc_4;
        logic [NBits-1:0]  rs1_data;
        logic [NBits-1:0]  rs2_data;
        logic [NBits-1:0]  imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [2:0]        funct3;
        logic              funct7;
        logic [CTRL_W-1:0] ctrl;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    // Load in EX whose destination a decode source needs. rs2 is compared
    // even for formats without rs2; an occasional spurious bubble is cheaper
    // than decoding the format here. x0 is never a real dependency.
    assign hazard = stage_q.valid & stage_q.ctrl[MEM_READ_BIT] &
                    (stage_q.rd_addr != '0) & bus.id_valid_i &
                    ((stage_q.rd_addr == bus.rs1_addr_i) |
                     (stage_q.rd_addr == bus.rs2_addr_i));

    // A taken branch kills the decode slot anyway, so no stall is requested.
    assign bus.hazard_stall_o = hazard & ~bus.flush_i;

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (bus.flush_i) begin
            stage_d = '0;
        end else if (bus.freeze_i) begin
            stage_d = stage_q;
        end else if (hazard) begin
            stage_d = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            stage_d.valid    = bus.id_valid_i;
            stage_d.pc       = bus.pc_i;
            stage_d.pc_4     = bus.pc_4_i;
            stage_d.rs1_data = bus.rs1_data_i;
            stage_d.rs2_data = bus.rs2_data_i;
            stage_d.imm      = bus.imm_i;
            stage_d.rs1_addr = bus.rs1_addr_i;
            stage_d.rs2_addr = bus.rs2_addr_i;
            stage_d.rd_addr  = bus.rd_addr_i;
            stage_d.funct3   = bus.funct3_i;
            stage_d.funct7   = bus.funct7_i;
            // An empty slot must never carry write enables into EX.
            stage_d.ctrl     = bus.id_valid_i ? bus.ctrl_i : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_valid_o     = stage_q.valid;
    assign bus.ex_pc_o        = stage_q.pc;
    assign bus.ex_pc_4_o      = stage_q.pc_4;
    assign bus.ex_rs1_data_o  = stage_q.rs1_data;
    assign bus.ex_rs2_data_o  = stage_q.rs2_data;
    assign bus.ex_imm_o       = stage_q.imm;
    assign bus.ex_rs1_addr_o  = stage_q.rs1_addr;
    assign bus.ex_rs2_addr_o  = stage_q.rs2_addr;
    assign bus.ex_rd_addr_o   = stage_q.rd_addr;
    assign bus.ex_funct3_o    = stage_q.funct3;
    assign bus.ex_funct7_o    = stage_q.funct7;
    assign bus.ex_ctrl_o      = stage_q.ctrl;
    assign bus.bubble_count_o = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;
    localparam int NB      = 32;
    localparam int AW      = 5;
    localparam int CW      = 12;
    localparam int CNW     = 2;
    localparam int MRB     = 5;
    localparam int CNT_MAX = (1 << CNW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.NBits(NB), .REG_AW(AW), .CTRL_W(CW), .CNT_W(CNW)) bus ();

    id_ex_stage_reg #(
        .NBits(NB), .REG_AW(AW), .CTRL_W(CW), .MEM_READ_BIT(MRB),
        .REG_WRITE_BIT(0), .CNT_W(CNW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Reference model: what the EX slot should hold, plus the bubble tally.
    typedef struct {
        bit               valid;
        logic [NB-1:0]    pc, pc_4, rs1_data, rs2_data, imm;
        logic [AW-1:0]    rs1_addr, rs2_addr, rd_addr;
        logic [2:0]       funct3;
        logic             funct7;
        logic [CW-1:0]    ctrl;
    } slot_t;

    slot_t m;
    int    m_cnt;
    int    checks = 0;
    int    failures = 0;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.pc = 0; s.pc_4 = 0; s.rs1_data = 0; s.rs2_data = 0;
        s.imm = 0; s.rs1_addr = 0; s.rs2_addr = 0; s.rd_addr = 0;
        s.funct3 = 0; s.funct7 = 0; s.ctrl = 0;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"},  64'(bus.ex_valid_o),    64'(m.valid));
        chk({tag, ".pc"},     64'(bus.ex_pc_o),       64'(m.pc));
        chk({tag, ".pc4"},    64'(bus.ex_pc_4_o),     64'(m.pc_4));
        chk({tag, ".rs1d"},   64'(bus.ex_rs1_data_o), 64'(m.rs1_data));
        chk({tag, ".rs2d"},   64'(bus.ex_rs2_data_o), 64'(m.rs2_data));
        chk({tag, ".imm"},    64'(bus.ex_imm_o),      64'(m.imm));
        chk({tag, ".rs1a"},   64'(bus.ex_rs1_addr_o), 64'(m.rs1_addr));
        chk({tag, ".rs2a"},   64'(bus.ex_rs2_addr_o), 64'(m.rs2_addr));
        chk({tag, ".rd"},     64'(bus.ex_rd_addr_o),  64'(m.rd_addr));
        chk({tag, ".f3"},     64'(bus.ex_funct3_o),   64'(m.funct3));
        chk({tag, ".f7"},     64'(bus.ex_funct7_o),   64'(m.funct7));
        chk({tag, ".ctrl"},   64'(bus.ex_ctrl_o),     64'(m.ctrl));
        chk({tag, ".bubbles"}, 64'(bus.bubble_count_o), 64'(m_cnt));
    endtask

    // A load sits in EX and the decoded instruction reads its destination.
    function automatic bit model_load_use();
        if (!m.valid || !m.ctrl[MRB] || m.rd_addr == 0 || !bus.id_valid_i) return 0;
        return (m.rd_addr == bus.rs1_addr_i) || (m.rd_addr == bus.rs2_addr_i);
    endfunction

    task automatic model_edge();
        bit lu;
        lu = model_load_use();
        if (bus.flush_i) begin
            m = empty_slot();
        end else if (bus.freeze_i) begin
            // slot and tally unchanged
        end else if (lu) begin
            m = empty_slot();
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m.valid    = bus.id_valid_i;
            m.pc       = bus.pc_i;
            m.pc_4     = bus.pc_4_i;
            m.rs1_data = bus.rs1_data_i;
            m.rs2_data = bus.rs2_data_i;
            m.imm      = bus.imm_i;
            m.rs1_addr = bus.rs1_addr_i;
            m.rs2_addr = bus.rs2_addr_i;
            m.rd_addr  = bus.rd_addr_i;
            m.funct3   = bus.funct3_i;
            m.funct7   = bus.funct7_i;
            m.ctrl     = bus.id_valid_i ? bus.ctrl_i : '0;
        end
    endtask

    // One clock: stall checked mid-cycle, slot checked just after the edge.
    task automatic step(input string tag);
        @(negedge clk);
        chk({tag, ".stall"}, 64'(bus.hazard_stall_o), 64'(model_load_use() && !bus.flush_i));
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic rand_inputs();
        bus.id_valid_i = ($urandom_range(0, 3) != 0);
        bus.pc_i       = $urandom;
        bus.pc_4_i     = $urandom;
        bus.rs1_data_i = $urandom;
        bus.rs2_data_i = $urandom;
        bus.imm_i      = $urandom;
        bus.rs1_addr_i = AW'($urandom_range(0, 3));
        bus.rs2_addr_i = AW'($urandom_range(0, 3));
        bus.rd_addr_i  = AW'($urandom_range(0, 3));
        bus.funct3_i   = 3'($urandom);
        bus.funct7_i   = 1'($urandom);
        bus.ctrl_i     = CW'($urandom);
        bus.flush_i    = 1'b0;
        bus.freeze_i   = 1'b0;
    endtask

    task automatic drive_instr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic [AW-1:0] rd, input logic [CW-1:0] ctrl);
        rand_inputs();
        bus.id_valid_i = 1'b1;
        bus.rs1_addr_i = rs1;
        bus.rs2_addr_i = rs2;
        bus.rd_addr_i  = rd;
        bus.ctrl_i     = ctrl;
    endtask

    initial begin
        logic [NB-1:0] held_pc;
        int            held_cnt;

        // Reset clears everything without a clock edge.
        reset = 1'b1;
        rand_inputs();
        m = empty_slot();
        m_cnt = 0;
        #1;
        chk_all("rst_async");
        chk("rst_stall", 64'(bus.hazard_stall_o), 64'd0);
        @(posedge clk);
        #1;
        chk_all("rst_hold");
        reset = 1'b0;

        // First load after reset: nothing visible until the edge.
        drive_instr(5'd1, 5'd2, 5'd7, 12'h0A1);
        bus.pc_i       = 32'h40;
        bus.rs1_data_i = 32'h1234;
        #1;
        chk_all("load_pre");
        step("load");
        chk("load_pc",    64'(bus.ex_pc_o), 64'h40);
        chk("load_rs1d",  64'(bus.ex_rs1_data_o), 64'h1234);
        chk("load_valid", 64'(bus.ex_valid_o), 64'd1);

        // lw x5 in EX, add reading x5 in ID: one bubble, then the add loads.
        drive_instr(5'd1, 5'd2, 5'd5, 12'h023);
        step("lw5");
        drive_instr(5'd5, 5'd3, 5'd6, 12'h001);
        #1;
        chk("hz_stall", 64'(bus.hazard_stall_o), 64'd1);
        step("hz");
        chk("hz_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("hz_ctrl",  64'(bus.ex_ctrl_o), 64'd0);
        chk("hz_cnt",   64'(bus.bubble_count_o), 64'd1);
        step("hz_load");
        chk("hz_load_rs1a",  64'(bus.ex_rs1_addr_o), 64'd5);
        chk("hz_load_valid", 64'(bus.ex_valid_o), 64'd1);

        // Load to x0 never stalls.
        drive_instr(5'd1, 5'd2, 5'd0, 12'h023);
        step("lw0");
        drive_instr(5'd0, 5'd0, 5'd3, 12'h001);
        step("x0_use");
        chk("x0_valid", 64'(bus.ex_valid_o), 64'd1);

        // Non-load writer of x5 never stalls.
        drive_instr(5'd1, 5'd2, 5'd5, 12'h001);
        step("alu5");
        drive_instr(5'd5, 5'd5, 5'd4, 12'h001);
        step("alu_use");
        chk("alu_valid", 64'(bus.ex_valid_o), 64'd1);

        // Flush wins over a hazard and a freeze; counter untouched.
        drive_instr(5'd1, 5'd2, 5'd5, 12'h023);
        step("fl_lw5");
        held_cnt = int'(bus.bubble_count_o);
        drive_instr(5'd5, 5'd1, 5'd6, 12'h001);
        bus.flush_i  = 1'b1;
        bus.freeze_i = 1'b1;
        #1;
        chk("fl_stall", 64'(bus.hazard_stall_o), 64'd0);
        step("flush");
        chk("fl_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("fl_cnt",   64'(bus.bubble_count_o), 64'(held_cnt));

        // Freeze holds the slot for three cycles of changing inputs.
        drive_instr(5'd1, 5'd2, 5'd3, 12'h0A1);
        step("fz_load");
        held_pc = bus.ex_pc_o;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            bus.freeze_i = 1'b1;
            step("freeze");
            chk("fz_pc", 64'(bus.ex_pc_o), 64'(held_pc));
        end

        // Repeated load-use pairs drive the counter into saturation.
        drive_instr(5'd5, 5'd5, 5'd5, 12'h023);
        for (int i = 0; i < 10; i++) step("sat");
        chk("sat_cnt", 64'(bus.bubble_count_o), 64'(CNT_MAX));

        // Random traffic with occasional flush, freeze and mid-run reset.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            bus.flush_i  = ($urandom_range(0, 7) == 0);
            bus.freeze_i = ($urandom_range(0, 5) == 0);
            step("rnd");
            if (i % 97 == 96) begin
                reset = 1'b1;
                #1;
                m = empty_slot();
                m_cnt = 0;
                chk_all("rnd_rst");
                #2;
                reset = 1'b0;
            end
        end

        // Reset in the middle of a cycle discards the in-flight instruction.
        drive_instr(5'd1, 5'd2, 5'd3, 12'h0A1);
        step("pre_rst");
        reset = 1'b1;
        #1;
        m = empty_slot();
        m_cnt = 0;
        chk_all("mid_rst");
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
